// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage FFT-processor pipeline: load-use bubbles,
// branch flushes and multdiv waits. Define PIPELINE_CTRL_PERF_EN to add the stall_cnt counter.
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_WIDTH  = 7,
    parameter int PERF_WIDTH = 32
) (
    input  logic clk,
    input  logic clr_n,
    input  logic ld_use_hazard,
    input  logic br_taken,
    input  logic md_start,
    input  logic md_rdy,
    output logic pc_en,
    output logic fd_en,
    output logic fd_clr,
    output logic dx_en,
    output logic dx_clr,
    output logic xm_en,
    output logic xm_clr,
    output logic mw_en,
    output logic md_busy,
    output logic md_err
`ifdef PIPELINE_CTRL_PERF_EN
    ,output logic [PERF_WIDTH-1:0] stall_cnt
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] MD_LAST = CNT_WIDTH'(MD_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 md_err_q, md_err_d;
    logic                 md_expired;

    assign md_expired = (cnt_q == MD_LAST);

    // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_clr   = 1'b0;
        dx_en    = 1'b1;
        dx_clr   = 1'b0;
        xm_en    = 1'b1;
        xm_clr   = 1'b0;
        mw_en    = 1'b1;
        md_busy  = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_err_d = md_err_q;

        if (!clr_n) begin
            // Reset must freeze the pipeline immediately, not at the next edge.
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_en  = 1'b0;
            mw_en  = 1'b0;
            fd_clr = 1'b1;
            dx_clr = 1'b1;
            xm_clr = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (br_taken) begin
                        fd_clr = 1'b1;
                        dx_clr = 1'b1;
                    end else if (ld_use_hazard) begin
                        pc_en  = 1'b0;
                        fd_en  = 1'b0;
                        dx_clr = 1'b1;
                    end
                    if (md_start) begin
                        state_d = MD_WAIT;
                        cnt_d   = '0;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (md_rdy || md_expired) begin
                        // A timeout still lets the garbage result advance so the pipeline never hangs.
                        state_d = RUN;
                        if (!md_rdy) begin
                            md_err_d = 1'b1;
                        end
                    end else begin
                        pc_en  = 1'b0;
                        fd_en  = 1'b0;
                        dx_en  = 1'b0;
                        xm_clr = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_err_q <= md_err_d;
        end
    end

    assign md_err = md_err_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cnt_q;

    // Saturating count of cycles with the PC held; reset is already excluded by the reset branch.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt_q <= '0;
        end else if (!pc_en && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a rule-level reference model.
module tb_pipeline_ctrl;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic clr_n;
    logic ld_use_hazard, br_taken, md_start, md_rdy;
    logic pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, xm_clr, mw_en, md_busy, md_err;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MD_TIMEOUT(TMO),
        .CNT_WIDTH (7),
        .PERF_WIDTH(32)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .ld_use_hazard(ld_use_hazard),
        .br_taken     (br_taken),
        .md_start     (md_start),
        .md_rdy       (md_rdy),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .fd_clr       (fd_clr),
        .dx_en        (dx_en),
        .dx_clr       (dx_clr),
        .xm_en        (xm_en),
        .xm_clr       (xm_clr),
        .mw_en        (mw_en),
        .md_busy      (md_busy),
        .md_err       (md_err)
`ifdef PIPELINE_CTRL_PERF_EN
        ,.stall_cnt   (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;

    // Reference model: whether a multdiv is outstanding, how long it has waited,
    // the sticky error, and the number of stalled cycles.
    bit          m_wait;
    int          m_elapsed;
    bit          m_err;
    int unsigned m_stalls;

    logic [9:0] obs;
    assign obs = {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, xm_clr, mw_en, md_busy, md_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected {pc,fd_en,fd_clr,dx_en,dx_clr,xm_en,xm_clr,mw_en,busy,err} from the rule table.
    function automatic logic [9:0] expected();
        if (!clr_n)
            return 10'b0_0_1_0_1_0_1_0_0_0;
        if (m_wait) begin
            if (md_rdy || m_elapsed == TMO - 1)
                return {8'b1_1_0_1_0_1_0_1, 1'b1, m_err};
            return {8'b0_0_0_0_0_1_1_1, 1'b1, m_err};
        end
        if (br_taken)
            return {8'b1_1_1_1_1_1_0_1, 1'b0, m_err};
        if (ld_use_hazard)
            return {8'b0_0_0_1_1_1_0_1, 1'b0, m_err};
        return {8'b1_1_0_1_0_1_0_1, 1'b0, m_err};
    endfunction

    task automatic model_step();
        logic [9:0] e;
        e = expected();
        if (!clr_n) begin
            m_wait    = 1'b0;
            m_elapsed = 0;
            m_err     = 1'b0;
            m_stalls  = 0;
        end else begin
            if (!e[9] && m_stalls != 32'hFFFF_FFFF)
                m_stalls++;
            if (m_wait) begin
                if (md_rdy) begin
                    m_wait = 1'b0;
                end else if (m_elapsed == TMO - 1) begin
                    m_wait = 1'b0;
                    m_err  = 1'b1;
                end else begin
                    m_elapsed++;
                end
            end else if (md_start) begin
                m_wait    = 1'b1;
                m_elapsed = 0;
            end
        end
    endtask

    // Entered #1 after a posedge; drives inputs, checks at negedge, advances the model at the next posedge.
    task automatic cycle(input logic ld, input logic br, input logic st, input logic rdy);
        ld_use_hazard = ld;
        br_taken      = br;
        md_start      = st;
        md_rdy        = rdy;
        @(negedge clk);
        check("ctrl", 32'(obs), 32'(expected()));
`ifdef PIPELINE_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, m_stalls);
`endif
        if (md_busy)
            busy_seen++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_wait = 1'b0; m_elapsed = 0; m_err = 1'b0; m_stalls = 0;
        clr_n = 1'b0;
        ld_use_hazard = 1'b0; br_taken = 1'b0; md_start = 1'b0; md_rdy = 1'b0;
        @(posedge clk);
        model_step();
        #1;

        // Reset with random inputs, then release.
        repeat (3) cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        check("rst_err", 32'(md_err), 32'd0);
        clr_n = 1'b1;
        cycle(0, 0, 0, 0);

        // Load-use bubble, then branch together with a hazard.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Multdiv answered five cycles after issue.
        cycle(0, 0, 1, 0);
        busy_seen = 0;
        for (int i = 1; i <= 5; i++)
            cycle(0, 0, 0, logic'(i == 5));
        check("md_busy_len", 32'(busy_seen), 32'd5);
        cycle(0, 0, 0, 0);

        // Multdiv that never answers.
        busy_seen = 0;
        cycle(0, 0, 1, 0);
        repeat (10) cycle(0, 0, 0, 0);
        check("tmo_busy_len", 32'(busy_seen), TMO);
        check("tmo_err_set", 32'(md_err), 32'd1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        check("tmo_err_sticky", 32'(md_err), 32'd1);

        // Asynchronous reset three cycles into a wait.
        cycle(0, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 0);
        @(negedge clk);
        check("pre_async_busy", 32'(md_busy), 32'd1);
        #2 clr_n = 1'b0;
        #1;
        check("async_busy", 32'(md_busy), 32'd0);
        check("async_err", 32'(md_err), 32'd0);
        check("async_ctrl", 32'(obs), 32'(expected()));
        @(posedge clk);
        model_step();
        #1;
        cycle(0, 0, 0, 0);
        clr_n = 1'b1;
        cycle(0, 0, 0, 0);
        check("post_async_pc_en", 32'(pc_en), 32'd1);

        // Random traffic with occasional reset pulses.
        repeat (1500) begin
            clr_n = ($urandom_range(0, 199) != 0);
            cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
